ov7670_pixel_capture: RTL and testbench

//  Camera-to-display bridge stage, single clock (clk, 100 MHz display clock).
//  - Oversamples the OV7670 pclk/href/vsync/data pins and assembles byte pairs into RGB565 pixels.
//  - Buffers pixels in a small FIFO and presents them as a valid/ready stream to the ILI9341 driver.
//  - Emits frameStart for the driver's initPixelStrobe; replaces direct pclk-domain gating of dataReady.

---
 rtl/ov7670_pkg.sv | 14 +
 rtl/ov7670_pixel_capture_fifo.sv | 59 +++++
 rtl/ov7670_pixel_capture.sv | 152 +++++++++++++++
 tb/tb_ov7670_pixel_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and frame geometry for the OV7670 capture path
package ov7670_pkg;

  typedef logic [15:0] rgb565_t;

  localparam int QVGA_WIDTH  = 320;
  localparam int QVGA_HEIGHT = 240;

  // The camera sends the high byte of each RGB565 pixel first.
  function automatic rgb565_t pack_pixel(input logic [7:0] i_hi, input logic [7:0] i_lo);
    return {i_hi, i_lo};
  endfunction

endpackage

// File: rtl/ov7670_pixel_capture_fifo.sv
// rtl/ov7670_pixel_capture_fifo.sv - first-word-fall-through pixel FIFO with flush
module pixel_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // A full FIFO still accepts a write when the head leaves on the same cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign empty   = (r_count == '0);
  assign full    = (r_count == LP_DEPTH);
  assign level   = r_count;
  assign popData = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= pushData;
  end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// rtl/ov7670_pixel_capture.sv - OV7670 pin oversampler, RGB565 assembler and pixel stream
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int H_PIXELS   = QVGA_WIDTH,
  parameter int V_LINES    = QVGA_HEIGHT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pclk,
  input  logic                          href,
  input  logic                          vsync,
  input  logic [7:0]                    OV7670_Data,
  input  logic                          pixelReady,
  output rgb565_t                       pixelData,
  output logic                          pixelValid,
  output logic                          frameStart,
  output logic                          frameDone,
  output logic [8:0]                    lineCount,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          overflow
);

  localparam logic [8:0] LP_H = 9'(H_PIXELS);
  localparam logic [8:0] LP_V = 9'(V_LINES);

  logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic       r_href_s1, r_href_s2, r_href_s3;
  logic       r_vsync_s1, r_vsync_s2, r_vsync_s3;
  logic [7:0] r_data_s1, r_data_s2;

  logic       r_armed;
  logic       r_phase;
  logic [7:0] r_hi;
  logic [8:0] r_pix_cnt;
  logic [8:0] r_line_cnt;
  logic       r_push;
  rgb565_t    r_push_data;
  logic       r_frame_start;
  logic       r_frame_done;
  logic       r_overflow;

  logic       w_byte_strobe;
  logic       w_vsync_rise;
  logic       w_href_fall;
  logic       w_capture;
  logic       w_pop;
  logic       w_empty;
  logic       w_full;
  rgb565_t    w_pop_data;

  assign w_byte_strobe = r_pclk_s2 & ~r_pclk_s3;
  assign w_vsync_rise  = r_vsync_s2 & ~r_vsync_s3;
  assign w_href_fall   = ~r_href_s2 & r_href_s3;
  assign w_capture     = r_armed & r_href_s2 & ~r_vsync_s2 & w_byte_strobe & (r_line_cnt < LP_V);
  assign w_pop         = ~w_empty & pixelReady;

  // Two-flop synchronisers plus an edge-detect stage; data tracks pclk so the byte lines up with its strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_pclk_s1, r_pclk_s2, r_pclk_s3}    <= '0;
      {r_href_s1, r_href_s2, r_href_s3}    <= '0;
      {r_vsync_s1, r_vsync_s2, r_vsync_s3} <= '0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      {r_pclk_s1, r_pclk_s2, r_pclk_s3}    <= {pclk, r_pclk_s1, r_pclk_s2};
      {r_href_s1, r_href_s2, r_href_s3}    <= {href, r_href_s1, r_href_s2};
      {r_vsync_s1, r_vsync_s2, r_vsync_s3} <= {vsync, r_vsync_s1, r_vsync_s2};
      r_data_s1 <= OV7670_Data;
      r_data_s2 <= r_data_s1;
    end
  end

  // Frame/line tracking and byte pairing; a partial frame after reset is skipped until vsync arms capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed       <= 1'b0;
      r_phase       <= 1'b0;
      r_hi          <= '0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_push        <= 1'b0;
      r_push_data   <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_start <= w_vsync_rise;
      r_frame_done  <= 1'b0;
      r_push        <= 1'b0;
      if (w_vsync_rise) begin
        r_armed    <= 1'b1;
        r_phase    <= 1'b0;
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
      end else if (w_capture) begin
        if (!r_phase) begin
          r_hi    <= r_data_s2;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (r_pix_cnt < LP_H) begin
            r_push      <= 1'b1;
            r_push_data <= pack_pixel(r_hi, r_data_s2);
            r_pix_cnt   <= r_pix_cnt + 9'd1;
          end
        end
      end else if (r_armed && w_href_fall) begin
        r_phase   <= 1'b0;
        r_pix_cnt <= '0;
        if ((r_pix_cnt != '0) && (r_line_cnt < LP_V)) begin
          r_line_cnt <= r_line_cnt + 9'd1;
          if (r_line_cnt == LP_V - 9'd1) r_frame_done <= 1'b1;
        end
      end
    end
  end

  // Sticky drop flag: a pixel arrived with no room and nothing leaving; a flush cycle discards it anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (r_push && w_full && !w_pop && !w_vsync_rise) begin
      r_overflow <= 1'b1;
    end
  end

  pixel_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (w_vsync_rise),
    .push     (r_push),
    .pushData (r_push_data),
    .pop      (w_pop),
    .popData  (w_pop_data),
    .empty    (w_empty),
    .full     (w_full),
    .level    (fifoLevel)
  );

  assign pixelValid = ~w_empty;
  assign pixelData  = w_empty ? '0 : w_pop_data;
  assign frameStart = r_frame_start;
  assign frameDone  = r_frame_done;
  assign lineCount  = r_line_cnt;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb/tb_ov7670_pixel_capture.sv - randomized bench for ov7670_pixel_capture against a frame-level model
module tb_ov7670_pixel_capture;

  localparam int DEPTH = 16;
  localparam int H     = 24;
  localparam int V     = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        pclk;
  logic        href;
  logic        vsync;
  logic [7:0]  OV7670_Data;
  logic        pixelReady = 1'b0;
  logic [15:0] pixelData;
  logic        pixelValid;
  logic        frameStart;
  logic        frameDone;
  logic [8:0]  lineCount;
  logic [4:0]  fifoLevel;
  logic        overflow;

  always #5 clk = ~clk;

  ov7670_pixel_capture #(
    .FIFO_DEPTH (DEPTH),
    .H_PIXELS   (H),
    .V_LINES    (V)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pclk        (pclk),
    .href        (href),
    .vsync       (vsync),
    .OV7670_Data (OV7670_Data),
    .pixelReady  (pixelReady),
    .pixelData   (pixelData),
    .pixelValid  (pixelValid),
    .frameStart  (frameStart),
    .frameDone   (frameDone),
    .lineCount   (lineCount),
    .fifoLevel   (fifoLevel),
    .overflow    (overflow)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  line_q[$];
  bit          m_armed  = 0;
  bit          m_ovf    = 0;
  int          m_lines  = 0;
  int          m_fs     = 0;
  int          m_fd     = 0;
  int          fs_cnt   = 0;
  int          fd_cnt   = 0;
  int          ready_mode = 1;
  bit          hold_en  = 0;
  bit          prev_v   = 0;
  bit          prev_r   = 0;
  logic [15:0] prev_d   = '0;
  bit          mon_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_line(input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(8'($urandom));
  endtask

  // Model: whole pixels of an accepted line, capped at H per line; nothing kept past V lines or while unarmed.
  task automatic send_line();
    int np;
    np = line_q.size() / 2;
    if (m_armed && m_lines < V) begin
      for (int k = 0; k < np; k++) begin
        if (k < H) begin
          if (ready_mode == 0 && exp_q.size() >= DEPTH) m_ovf = 1;
          else exp_q.push_back({line_q[2*k], line_q[2*k+1]});
        end
      end
      if (np > 0) begin
        m_lines++;
        if (m_lines == V) m_fd++;
      end
    end
    href = 1'b1;
    tick(3);
    foreach (line_q[i]) begin
      OV7670_Data = line_q[i];
      pclk = 1'b0;
      tick(3);
      pclk = 1'b1;
      tick(3);
    end
    pclk = 1'b0;
    tick(2);
    href = 1'b0;
    tick(6);
  endtask

  task automatic pulse_vsync();
    hold_en = 0;
    exp_q.delete();
    m_lines = 0;
    m_armed = 1;
    m_fs++;
    vsync = 1'b1;
    tick(6);
    vsync = 1'b0;
    tick(6);
    hold_en = 1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    ready_mode = 2;
    while (exp_q.size() != 0 && t < 3000) begin
      tick(1);
      t++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    tick(4);
    chk({tag, "_valid_low"}, pixelValid, 0);
    chk({tag, "_level_zero"}, fifoLevel, 0);
  endtask

  // Consumer: picks pixelReady, scores transfers against the model and checks stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      pixelReady = 1'b0;
      prev_v = 0;
    end else begin
      if (frameStart) fs_cnt++;
      if (frameDone) begin
        fd_cnt++;
        chk("frame_done_line_count", 32'(lineCount), V);
      end
      if (hold_en && prev_v && !prev_r) begin
        chk("stall_valid_held", pixelValid, 1);
        chk("stall_data_held", pixelData, prev_d);
      end
      case (ready_mode)
        1:       mon_r = 1'b1;
        2:       mon_r = ($urandom_range(0, 3) != 0);
        default: mon_r = 1'b0;
      endcase
      if (pixelValid && mon_r) begin
        if (exp_q.size() == 0) chk("unexpected_pixel", pixelValid, 0);
        else chk("pixel_data", pixelData, exp_q.pop_front());
      end
      pixelReady = mon_r;
      prev_v = pixelValid;
      prev_r = mon_r;
      prev_d = pixelData;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    pclk = 1'b0;
    href = 1'b0;
    vsync = 1'b0;
    OV7670_Data = '0;
    tick(5);
    chk("reset_valid", pixelValid, 0);
    chk("reset_data", pixelData, 0);
    chk("reset_frame_start", frameStart, 0);
    chk("reset_frame_done", frameDone, 0);
    chk("reset_line_count", lineCount, 0);
    chk("reset_level", fifoLevel, 0);
    chk("reset_overflow", overflow, 0);
    reset = 1'b1;
    tick(3);

    // Bytes before the first vsync are ignored.
    ready_mode = 1;
    rand_line(8);
    send_line();
    tick(10);
    chk("prearm_level", fifoLevel, 0);
    chk("prearm_frame_start", fs_cnt, m_fs);

    // First frame, fixed A1 B2 C3 D4 line.
    pulse_vsync();
    chk("t1_frame_start_once", fs_cnt, 1);
    ready_mode = 0;
    line_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_line();
    tick(4);
    chk("t1_head_pixel", pixelData, 16'hA1B2);
    chk("t1_level", fifoLevel, 2);
    drain("t1");
    chk("t1_line_count", lineCount, 1);

    // Odd line: trailing byte discarded, next line starts on a fresh pair.
    ready_mode = 0;
    rand_line(5);
    send_line();
    tick(4);
    chk("t4_odd_level", fifoLevel, 2);
    rand_line(4);
    send_line();
    tick(4);
    chk("t4_next_level", fifoLevel, 4);
    drain("t4");
    chk("t4_line_count", lineCount, m_lines);

    // Stalled consumer: 20 pixels into a 16-entry FIFO.
    ready_mode = 0;
    rand_line(40);
    send_line();
    tick(6);
    chk("t3_level_full", fifoLevel, DEPTH);
    chk("t3_overflow", overflow, m_ovf);
    drain("t3");

    // Frame of V+1 full-width lines; the last is ignored. Overflow stays sticky across vsync.
    pulse_vsync();
    chk("t5_overflow_sticky", overflow, 1);
    ready_mode = 2;
    for (int l = 0; l < V + 1; l++) begin
      rand_line(2 * H);
      send_line();
    end
    drain("t5");
    chk("t5_frame_done_count", fd_cnt, m_fd);
    chk("t5_line_count_hold", lineCount, V);

    // Random line lengths, including empty and over-long lines.
    pulse_vsync();
    ready_mode = 2;
    for (int l = 0; l < V + 2; l++) begin
      rand_line($urandom_range(0, 2 * H + 7));
      send_line();
    end
    drain("t7");
    chk("t7_line_count", lineCount, m_lines);
    chk("t7_frame_done_count", fd_cnt, m_fd);
    chk("t7_frame_start_count", fs_cnt, m_fs);

    // Reset mid-line with three pixels queued.
    pulse_vsync();
    ready_mode = 0;
    rand_line(6);
    send_line();
    tick(4);
    chk("t6_queued", fifoLevel, 3);
    hold_en = 0;
    href = 1'b1;
    tick(3);
    reset = 1'b0;
    #1;
    chk("t6_valid_dropped", pixelValid, 0);
    chk("t6_level_dropped", fifoLevel, 0);
    exp_q.delete();
    m_armed = 0;
    m_lines = 0;
    m_ovf = 0;
    tick(3);
    reset = 1'b1;
    href = 1'b0;
    tick(5);
    chk("t6_overflow_cleared", overflow, m_ovf);
    ready_mode = 1;
    rand_line(8);
    send_line();
    tick(10);
    chk("t6_unarmed_level", fifoLevel, 0);
    chk("t6_unarmed_lines", lineCount, 0);
    pulse_vsync();
    rand_line(4);
    send_line();
    drain("t6");
    chk("t6_line_count", lineCount, 1);
    chk("final_frame_start_count", fs_cnt, m_fs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
